// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Serial bit-pattern transmitter. On start (sampled only while idle) the
//   pattern, effective length and repeat count are captured; the pattern is
//   then shifted out LSB-first, one bit per clock, for rep+1 frames with GAP
//   idle cycles between frames. x, x_valid, done (and exp_y) are registered.
//
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous, active-low reset
//     start    transmit request, honoured only in IDLE
//     pattern  WIDTH bits to send, pattern[0] first
//     len      bits per frame; 0 or >WIDTH selects WIDTH
//     rep      extra repetitions (frames = rep+1)
//     x        serial data (IDLE_BIT when not transmitting)
//     x_valid  high while x carries a pattern bit
//     busy     high in every state except IDLE
//     done     one-cycle pulse after the final bit
//     exp_y    (SPT_EXPECT_EN only) Mealy output a 0110 detector should show
//              for the bit currently on x
//
//   Optional feature macro: SPT_EXPECT_EN (adds exp_y and the bit history).
module serial_pattern_tx #(
  parameter int WIDTH    = 16,
  parameter int LEN_W    = 5,
  parameter int REP_W    = 4,
  parameter int GAP      = 0,
  parameter int IDLE_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] rep,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
`ifdef SPT_EXPECT_EN
  ,
  output logic             exp_y
`endif
);

  localparam int   GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic IDLE_V = (IDLE_BIT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  pat_q, pat_n;
  logic [WIDTH-1:0]  sh_q, sh_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  bit_q, bit_n;
  logic [REP_W-1:0]  frames_q, frames_n;
  logic [GAP_W-1:0]  gap_q, gap_n;
  logic              x_n, x_valid_n, done_n;
  logic [LEN_W-1:0]  eff_len;

  assign eff_len = ((len == '0) || (len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : len;
  assign busy    = (state != S_IDLE);

  // bit_q counts the bits already put on x in the current frame, so the
  // frame ends at the edge where bit_q == len_q. x is loaded one edge ahead
  // of the bit it shows, which gives the single-cycle start latency.
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    sh_n      = sh_q;
    len_n     = len_q;
    bit_n     = bit_q;
    frames_n  = frames_q;
    gap_n     = gap_q;
    x_n       = IDLE_V;
    x_valid_n = 1'b0;
    done_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          pat_n     = pattern;
          len_n     = eff_len;
          frames_n  = rep;
          x_n       = pattern[0];
          sh_n      = pattern >> 1;
          bit_n     = LEN_W'(1);
          x_valid_n = 1'b1;
          state_n   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bit_q == len_q) begin
          if (frames_q != '0) begin
            frames_n = frames_q - REP_W'(1);
            if (GAP > 0) begin
              gap_n   = GAP_W'(1);
              state_n = S_GAP;
            end else begin
              x_n       = pat_q[0];
              sh_n      = pat_q >> 1;
              bit_n     = LEN_W'(1);
              x_valid_n = 1'b1;
            end
          end else begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end
        end else begin
          x_n       = sh_q[0];
          sh_n      = sh_q >> 1;
          bit_n     = bit_q + LEN_W'(1);
          x_valid_n = 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_W'(GAP)) begin
          x_n       = pat_q[0];
          sh_n      = pat_q >> 1;
          bit_n     = LEN_W'(1);
          x_valid_n = 1'b1;
          state_n   = S_SHIFT;
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      pat_q    <= '0;
      sh_q     <= '0;
      len_q    <= '0;
      bit_q    <= '0;
      frames_q <= '0;
      gap_q    <= '0;
      x        <= IDLE_V;
      x_valid  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pat_q    <= pat_n;
      sh_q     <= sh_n;
      len_q    <= len_n;
      bit_q    <= bit_n;
      frames_q <= frames_n;
      gap_q    <= gap_n;
      x        <= x_n;
      x_valid  <= x_valid_n;
      done     <= done_n;
    end
  end

`ifdef SPT_EXPECT_EN
  // hist holds the last three emitted bits (hist[0] newest); hcnt saturates
  // at 3 so a freshly cleared history cannot complete 0110 with fewer bits.
  logic [2:0] hist_q, hist_n, hist_base;
  logic [1:0] hcnt_q, hcnt_n, hcnt_base;
  logic       exp_y_n;
  logic       clr;

  assign clr = (state == S_IDLE) && start;

  always_comb begin
    hist_base = clr ? 3'b000 : hist_q;
    hcnt_base = clr ? 2'd0   : hcnt_q;
    hist_n    = hist_base;
    hcnt_n    = hcnt_base;
    exp_y_n   = 1'b0;
    if (x_valid_n) begin
      exp_y_n = !x_n && (hcnt_base == 2'd3) && (hist_base == 3'b011);
      hist_n  = {hist_base[1:0], x_n};
      hcnt_n  = (hcnt_base == 2'd3) ? 2'd3 : hcnt_base + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      hcnt_q <= '0;
      exp_y  <= 1'b0;
    end else begin
      hist_q <= hist_n;
      hcnt_q <= hcnt_n;
      exp_y  <= exp_y_n;
    end
  end
`endif

endmodule
